frame_window_sequencer: RTL

FRAME_WINDOW_SEQUENCER -- requirements
Module: frame_window_sequencer

---
 rtl/frame_window_sequencer.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/frame_window_sequencer.sv
// frame_window_sequencer
//   Sequences a raster pixel stream into a 3x3 line/frame buffer and issues
//   window reads. A row of windows can only be read once the row below it
//   has been written, so writes and reads interleave row by row. The last
//   row's windows are read without a further write phase.
//
// Ports
//   I_CLK, I_RESET            clock, synchronous active-high reset
//   I_START                   frame start request (sampled in IDLE only)
//   I_PIXEL_VALID / I_PIXEL   upstream pixel stream, raster order
//   O_PIXEL_READY             pixel accepted when high with I_PIXEL_VALID
//   O_BUF_ROW / O_BUF_COLUMN  buffer address (write or window read)
//   O_BUF_PIXEL               buffer write data
//   O_BUF_WRITE_ENABLE        buffer write strobe
//   O_BUF_READ_ENABLE         buffer window-read strobe
//   I_WINDOW_READY            downstream accepts the current window
//   O_WINDOW_VALID            buffer matrix output holds an unconsumed window
//   O_CENTER_ROW/_COLUMN      center address of the valid window
//   O_BUSY                    high whenever not IDLE
//   O_FRAME_DONE              one-cycle pulse as the final window is accepted
module frame_window_sequencer #(
  parameter int P_COLUMNS     = 640,
  parameter int P_ROWS        = 4,
  parameter int P_PIXEL_DEPTH = 8,
  localparam int P_COLUMNS_BITS = $clog2(P_COLUMNS),
  localparam int P_ROWS_BITS    = $clog2(P_ROWS)
) (
  input  logic                      I_CLK,
  input  logic                      I_RESET,
  input  logic                      I_START,
  input  logic                      I_PIXEL_VALID,
  input  logic [P_PIXEL_DEPTH-1:0]  I_PIXEL,
  output logic                      O_PIXEL_READY,
  output logic [P_COLUMNS_BITS-1:0] O_BUF_COLUMN,
  output logic [P_ROWS_BITS-1:0]    O_BUF_ROW,
  output logic [P_PIXEL_DEPTH-1:0]  O_BUF_PIXEL,
  output logic                      O_BUF_WRITE_ENABLE,
  output logic                      O_BUF_READ_ENABLE,
  input  logic                      I_WINDOW_READY,
  output logic                      O_WINDOW_VALID,
  output logic [P_COLUMNS_BITS-1:0] O_CENTER_COLUMN,
  output logic [P_ROWS_BITS-1:0]    O_CENTER_ROW,
  output logic                      O_BUSY,
  output logic                      O_FRAME_DONE
);

  localparam logic [P_COLUMNS_BITS-1:0] COL_LAST = P_COLUMNS_BITS'(P_COLUMNS - 1);
  localparam logic [P_ROWS_BITS-1:0]    ROW_LAST = P_ROWS_BITS'(P_ROWS - 1);
  localparam logic [P_COLUMNS_BITS-1:0] COL_ONE  = P_COLUMNS_BITS'(1);
  localparam logic [P_ROWS_BITS-1:0]    ROW_ONE  = P_ROWS_BITS'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_LAST,
    S_DRAIN
  } state_e;

  state_e                    state_q, state_d;
  logic [P_ROWS_BITS-1:0]    wr_row_q, wr_row_d;
  logic [P_COLUMNS_BITS-1:0] wr_col_q, wr_col_d;
  logic [P_ROWS_BITS-1:0]    rd_row_q, rd_row_d;
  logic [P_COLUMNS_BITS-1:0] rd_col_q, rd_col_d;
  logic                      win_valid_q, win_valid_d;
  logic [P_ROWS_BITS-1:0]    ctr_row_q, ctr_row_d;
  logic [P_COLUMNS_BITS-1:0] ctr_col_q, ctr_col_d;

  logic pix_ready;
  logic accept;
  logic rd_issue;
  logic handshake;
  logic frame_done;

  // Strobes are masked while reset is asserted so nothing reaches the
  // buffer during the reset cycle, even if the state is still mid-frame.
  always_comb begin
    pix_ready  = (state_q == S_WRITE) && !I_RESET;
    accept     = pix_ready && I_PIXEL_VALID;
    // A new window may be read when the output slot is empty or is being
    // consumed this very cycle; that overlap gives one window per cycle.
    rd_issue   = ((state_q == S_READ) || (state_q == S_LAST)) &&
                 (!win_valid_q || I_WINDOW_READY) && !I_RESET;
    handshake  = win_valid_q && I_WINDOW_READY;
    frame_done = (state_q == S_DRAIN) && handshake && !I_RESET;
  end

  always_comb begin
    state_d  = state_q;
    wr_row_d = wr_row_q;
    wr_col_d = wr_col_q;
    rd_row_d = rd_row_q;
    rd_col_d = rd_col_q;

    case (state_q)
      S_IDLE: begin
        if (I_START) begin
          state_d  = S_WRITE;
          wr_row_d = '0;
          wr_col_d = '0;
        end
      end
      S_WRITE: begin
        if (accept) begin
          if (wr_col_q == COL_LAST) begin
            wr_col_d = '0;
            // Row 0 has no row below it yet, so keep writing into row 1
            // before any window of row 0 can be formed.
            if (wr_row_q == '0) begin
              wr_row_d = ROW_ONE;
            end else begin
              state_d  = S_READ;
              rd_row_d = wr_row_q - ROW_ONE;
              rd_col_d = '0;
            end
          end else begin
            wr_col_d = wr_col_q + COL_ONE;
          end
        end
      end
      S_READ: begin
        if (rd_issue) begin
          if (rd_col_q == COL_LAST) begin
            rd_col_d = '0;
            if (wr_row_q == ROW_LAST) begin
              state_d  = S_LAST;
              rd_row_d = ROW_LAST;
            end else begin
              state_d  = S_WRITE;
              wr_row_d = wr_row_q + ROW_ONE;
            end
          end else begin
            rd_col_d = rd_col_q + COL_ONE;
          end
        end
      end
      S_LAST: begin
        if (rd_issue) begin
          if (rd_col_q == COL_LAST) begin
            state_d  = S_DRAIN;
            rd_col_d = '0;
          end else begin
            rd_col_d = rd_col_q + COL_ONE;
          end
        end
      end
      S_DRAIN: begin
        if (handshake) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Window slot: a read refills it, a handshake without a refill empties
  // it, otherwise it holds (the buffer keeps its matrix while unread).
  always_comb begin
    win_valid_d = win_valid_q;
    ctr_row_d   = ctr_row_q;
    ctr_col_d   = ctr_col_q;
    if (rd_issue) begin
      win_valid_d = 1'b1;
      ctr_row_d   = rd_row_q;
      ctr_col_d   = rd_col_q;
    end else if (handshake) begin
      win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q     <= S_IDLE;
      wr_row_q    <= '0;
      wr_col_q    <= '0;
      rd_row_q    <= '0;
      rd_col_q    <= '0;
      win_valid_q <= 1'b0;
      ctr_row_q   <= '0;
      ctr_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_row_q    <= wr_row_d;
      wr_col_q    <= wr_col_d;
      rd_row_q    <= rd_row_d;
      rd_col_q    <= rd_col_d;
      win_valid_q <= win_valid_d;
      ctr_row_q   <= ctr_row_d;
      ctr_col_q   <= ctr_col_d;
    end
  end

  // Write and read cannot coincide (disjoint states); the address bus
  // rests at zero when neither strobe is active.
  always_comb begin
    O_BUF_ROW    = '0;
    O_BUF_COLUMN = '0;
    O_BUF_PIXEL  = '0;
    if (accept) begin
      O_BUF_ROW    = wr_row_q;
      O_BUF_COLUMN = wr_col_q;
      O_BUF_PIXEL  = I_PIXEL;
    end else if (rd_issue) begin
      O_BUF_ROW    = rd_row_q;
      O_BUF_COLUMN = rd_col_q;
    end
  end

  assign O_PIXEL_READY      = pix_ready;
  assign O_BUF_WRITE_ENABLE = accept;
  assign O_BUF_READ_ENABLE  = rd_issue;
  assign O_WINDOW_VALID     = win_valid_q;
  assign O_CENTER_ROW       = ctr_row_q;
  assign O_CENTER_COLUMN    = ctr_col_q;
  assign O_BUSY             = (state_q != S_IDLE);
  assign O_FRAME_DONE       = frame_done;

endmodule
